uart_rx_byte: RTL and testbench
===============================

UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port data_out  output  8  last correctly framed byte, held until next good byte.
REQ-006 SHALL have port byteReady  output  1  one-cycle strobe, data_out newly valid; consumed by uart_ram.
REQ-007 SHALL have port frame_err  output  1  one-cycle strobe, stop bit sampled low.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a bit-period counter (16 bit) and a 3-bit bit index.
REQ-011 IDLE: counter=0; on rx_s==0 -> START.
REQ-012 START: counter increments each cycle; at counter==CLKS_PER_BIT/2-1 (integer division), rx_s==0 -> DATA with counter=0, bit index=0; rx_s==1 -> IDLE (glitch reject, no strobe).
REQ-013 DATA: at counter==CLKS_PER_BIT-1 sample rx_s into shift register bit[index], counter=0, index+1; after index 7 sampled -> STOP.
REQ-014 STOP: at counter==CLKS_PER_BIT-1 sample rx_s; 1 -> data_out<=shift register, byteReady=1 for exactly that next cycle, -> IDLE; 0 -> frame_err=1 for one cycle, data_out unchanged, -> WAIT_HIGH.
REQ-015 WAIT_HIGH: remain until rx_s==1, then -> IDLE; a held-low line (break) SHALL NOT produce further bytes or error strobes.
REQ-016 byteReady and frame_err SHALL never be high in the same cycle and SHALL not depend on any downstream acknowledge (no backpressure; consumer must take data within one byte time).
REQ-017 Latency: byteReady rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after rx falling edge at start bit, +/-0.
REQ-018 Back-to-back frames: IDLE reached at stop-bit mid-point, so a start edge arriving at any later cycle SHALL be accepted.
REQ-019 Counter SHALL never wrap; it resets to 0 on every state transition.

Reset
REQ-020 reset high at clock edge SHALL force state IDLE, counter=0, index=0, shift register=0, data_out=8'h00, byteReady=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-021 reset asserted mid-frame SHALL abort the frame with no strobe; reception resumes only on a new falling edge after reset deasserts.

Verification (CLKS_PER_BIT=16)
REQ-022 Send 8'hA5 with valid stop -> one byteReady pulse, data_out=8'hA5, frame_err never high, latency per REQ-017 (=155 cycles).
REQ-023 Send 8'h3C then 8'hFF back-to-back (zero idle bits) -> two byteReady pulses, data_out 8'h3C then 8'hFF.
REQ-024 Low glitch of 5 cycles on idle rx -> returns to IDLE, no byteReady, no frame_err, busy high at most 8+2 cycles.
REQ-025 Send 8'h55 with stop bit low then hold rx low 40 bit-times -> exactly one frame_err pulse, data_out unchanged, no byteReady; after rx returns high, 8'h12 received correctly.
REQ-026 Assert reset for 1 cycle during bit 4 of 8'h81 -> no strobe, all outputs at reset values; following 8'h7E received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/error strobes.
// A held-low line after a framing error or reset never yields a byte until it has gone high.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       byteReady,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

  logic        sync1_q, sync2_q;
  logic        rx_s;
  logic [1:0]  fill_q, fill_d;
  logic        armed_q, armed_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic        busy_q;

  assign rx_s      = sync2_q;
  assign data_out  = data_q;
  assign byteReady = ready_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

  // Next-state logic; armed_q requires a genuinely sampled high line before a start is
  // accepted, so the reset value of the synchronizer cannot fake a falling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (rx_s & (fill_q == 2'b11));
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (armed_q && !rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 16'd0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = 16'd0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = 16'd0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus randomized frames
// compared against an event-level model (expected bytes, arrival cycles, error counts).
module tb_uart_rx_byte;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       byteReady;
  logic       frame_err;
  logic       busy;

  int n_checks;
  int n_pass;
  int cyc;
  int ferr_total;
  int both_total;
  int busy_run;
  logic [7:0] got_data[$];
  int         got_cyc[$];
  int         busy_runs[$];
  logic [7:0] last_good;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .byteReady (byteReady),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (byteReady) begin
      got_data.push_back(data_out);
      got_cyc.push_back(cyc);
    end
    if (frame_err) ferr_total = ferr_total + 1;
    if (byteReady && frame_err) both_total = both_total + 1;
    if (busy) begin
      busy_run = busy_run + 1;
    end else begin
      if (busy_run != 0) busy_runs.push_back(busy_run);
      busy_run = 0;
    end
  end

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, output int start_c);
    start_c = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data got %h expected 00", data_out); else n_pass++;
    n_checks++; if (byteReady !== 1'b0) $display("FAIL reset_byteReady got %b expected 0", byteReady); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b expected 0", frame_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else n_pass++;
    reset = 1'b0;
    last_good = 8'h00;
    idle_cycles(3 * CPB);
  endtask

  task automatic test_single;
    int base, fbase, st;
    base = got_data.size();
    fbase = ferr_total;
    send_frame(8'hA5, 1'b1, st);
    idle_cycles(2 * CPB);
    n_checks++; if (got_data.size() - base !== 1) $display("FAIL single_count got %0d expected 1", got_data.size() - base); else n_pass++;
    if (got_data.size() > base) begin
      n_checks++; if (got_data[base] !== 8'hA5) $display("FAIL single_data got %h expected a5", got_data[base]); else n_pass++;
      n_checks++; if (got_cyc[base] - st !== LAT) $display("FAIL single_latency got %0d expected %0d", got_cyc[base] - st, LAT); else n_pass++;
      last_good = 8'hA5;
    end
    n_checks++; if (ferr_total - fbase !== 0) $display("FAIL single_ferr got %0d expected 0", ferr_total - fbase); else n_pass++;
    n_checks++; if (data_out !== 8'hA5) $display("FAIL single_hold got %h expected a5", data_out); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int base, st0, st1;
    base = got_data.size();
    send_frame(8'h3C, 1'b1, st0);
    send_frame(8'hFF, 1'b1, st1);
    idle_cycles(2 * CPB);
    n_checks++; if (got_data.size() - base !== 2) $display("FAIL b2b_count got %0d expected 2", got_data.size() - base); else n_pass++;
    if (got_data.size() >= base + 2) begin
      n_checks++; if (got_data[base] !== 8'h3C) $display("FAIL b2b_first got %h expected 3c", got_data[base]); else n_pass++;
      n_checks++; if (got_data[base+1] !== 8'hFF) $display("FAIL b2b_second got %h expected ff", got_data[base+1]); else n_pass++;
      n_checks++; if (got_cyc[base+1] - st1 !== LAT) $display("FAIL b2b_latency got %0d expected %0d", got_cyc[base+1] - st1, LAT); else n_pass++;
      last_good = 8'hFF;
    end
  endtask

  task automatic test_glitch;
    int base, fbase, rbase, mx;
    base = got_data.size();
    fbase = ferr_total;
    rbase = busy_runs.size();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle_cycles(3 * CPB);
    mx = 0;
    for (int i = rbase; i < busy_runs.size(); i++) if (busy_runs[i] > mx) mx = busy_runs[i];
    n_checks++; if (got_data.size() - base !== 0) $display("FAIL glitch_bytes got %0d expected 0", got_data.size() - base); else n_pass++;
    n_checks++; if (ferr_total - fbase !== 0) $display("FAIL glitch_ferr got %0d expected 0", ferr_total - fbase); else n_pass++;
    n_checks++; if (mx < 1 || mx > CPB / 2 + 2) $display("FAIL glitch_busy got %0d expected 1..%0d", mx, CPB / 2 + 2); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_idle got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_break;
    int base, fbase, st;
    base = got_data.size();
    fbase = ferr_total;
    send_frame(8'h55, 1'b0, st);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL break_busy got %b expected 1", busy); else n_pass++;
    idle_cycles(2 * CPB);
    n_checks++; if (ferr_total - fbase !== 1) $display("FAIL break_ferr got %0d expected 1", ferr_total - fbase); else n_pass++;
    n_checks++; if (got_data.size() - base !== 0) $display("FAIL break_bytes got %0d expected 0", got_data.size() - base); else n_pass++;
    n_checks++; if (data_out !== last_good) $display("FAIL break_hold got %h expected %h", data_out, last_good); else n_pass++;
    base = got_data.size();
    send_frame(8'h12, 1'b1, st);
    idle_cycles(2 * CPB);
    n_checks++; if (got_data.size() - base !== 1) $display("FAIL break_recover_count got %0d expected 1", got_data.size() - base); else n_pass++;
    n_checks++; if (data_out !== 8'h12) $display("FAIL break_recover_data got %h expected 12", data_out); else n_pass++;
    last_good = 8'h12;
  endtask

  task automatic test_reset_midframe;
    int base, fbase, st;
    logic [7:0] b;
    b = 8'h81;
    base = got_data.size();
    fbase = ferr_total;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (data_out !== 8'h00) $display("FAIL rst_mid_data got %h expected 00", data_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b expected 0", busy); else n_pass++;
    n_checks++; if (byteReady !== 1'b0 || frame_err !== 1'b0) $display("FAIL rst_mid_strobes got %b%b expected 00", byteReady, frame_err); else n_pass++;
    last_good = 8'h00;
    repeat (CPB / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    idle_cycles(3 * CPB);
    n_checks++; if (got_data.size() - base !== 0) $display("FAIL rst_mid_bytes got %0d expected 0", got_data.size() - base); else n_pass++;
    n_checks++; if (ferr_total - fbase !== 0) $display("FAIL rst_mid_ferr got %0d expected 0", ferr_total - fbase); else n_pass++;
    send_frame(8'h7E, 1'b1, st);
    idle_cycles(2 * CPB);
    n_checks++; if (got_data.size() - base !== 1) $display("FAIL rst_mid_next_count got %0d expected 1", got_data.size() - base); else n_pass++;
    if (got_data.size() > base) begin
      n_checks++; if (got_data[base] !== 8'h7E) $display("FAIL rst_mid_next_data got %h expected 7e", got_data[base]); else n_pass++;
      n_checks++; if (got_cyc[base] - st !== LAT) $display("FAIL rst_mid_next_latency got %0d expected %0d", got_cyc[base] - st, LAT); else n_pass++;
      last_good = 8'h7E;
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    int base, fbase, exp_ferr, st, gap;
    logic [7:0] b;
    logic good;
    base = got_data.size();
    fbase = ferr_total;
    exp_ferr = 0;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good, st);
      if (good) begin
        exp_data.push_back(b);
        exp_cyc.push_back(st + LAT);
        last_good = b;
        gap = $urandom_range(0, 20);
      end else begin
        exp_ferr++;
        gap = $urandom_range(4, 30);
      end
      idle_cycles(gap);
    end
    idle_cycles(2 * CPB);
    n_checks++; if (got_data.size() - base !== exp_data.size()) $display("FAIL rand_count got %0d expected %0d", got_data.size() - base, exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && base + i < got_data.size(); i++) begin
      n_checks++; if (got_data[base+i] !== exp_data[i]) $display("FAIL rand_data[%0d] got %h expected %h", i, got_data[base+i], exp_data[i]); else n_pass++;
      n_checks++; if (got_cyc[base+i] !== exp_cyc[i]) $display("FAIL rand_cycle[%0d] got %0d expected %0d", i, got_cyc[base+i], exp_cyc[i]); else n_pass++;
    end
    n_checks++; if (ferr_total - fbase !== exp_ferr) $display("FAIL rand_ferr got %0d expected %0d", ferr_total - fbase, exp_ferr); else n_pass++;
    n_checks++; if (data_out !== last_good) $display("FAIL rand_hold got %h expected %h", data_out, last_good); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    ferr_total = 0;
    both_total = 0;
    busy_run = 0;
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_random();
    n_checks++; if (both_total !== 0) $display("FAIL exclusive_strobes got %0d expected 0", both_total); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
